// File: rtl/mmio_gpio_pkg.sv
// Shared constants for the memory-mapped GPIO block: window location,
// register offsets and button count.
package mmio_gpio_pkg;

  localparam int GPIO_WINDOW_BITS = 3;
  localparam int GPIO_NUM_BTN     = 5;

  localparam logic [10:0] GPIO_BASE = 11'h7F8;

  typedef logic [GPIO_WINDOW_BITS-1:0] gpio_off_t;

  localparam gpio_off_t GPIO_OFF_LED   = 3'd0;
  localparam gpio_off_t GPIO_OFF_SW    = 3'd1;
  localparam gpio_off_t GPIO_OFF_BTN   = 3'd2;
  localparam gpio_off_t GPIO_OFF_PRESS = 3'd3;

endpackage

// File: rtl/gpio_debounce.sv
// One button channel: 2-flop synchronizer, stability counter and debounced
// level, plus a one-cycle pulse coincident with each 0->1 level change.
module gpio_debounce #(
  parameter int g_DB_BITS = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic                 meta_q, sync_q;
  logic                 level_q, level_d;
  logic [g_DB_BITS-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + {{(g_DB_BITS-1){1'b0}}, 1'b1};

  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q != level_q) begin
      if (cnt_inc == '1) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= i_async;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = level_d & ~level_q;

endmodule

// File: rtl/mmio_gpio.sv
// GPIO peripheral sitting beside the data RAM: decodes an 8-word window and
// serves LED, switch, debounced button and sticky press-flag registers.
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter int                g_ADDR      = 11,
  parameter int                g_WIDTH     = 9,
  parameter logic [g_ADDR-1:0] g_BASE      = GPIO_BASE,
  parameter logic [7:0]        g_LED_RESET = 8'h99,
  parameter int                g_DB_BITS   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [g_ADDR-1:0]  i_addr,
  input  logic [g_WIDTH-1:0] i_data,
  output logic [g_WIDTH-1:0] o_data,
  output logic               o_sel,
  output logic [7:0]         o_led,
  input  logic [7:0]         i_sw,
  input  logic [4:0]         i_btn
);

  logic      hit, wr, rd;
  gpio_off_t off;

  logic [7:0]              led_q, led_d;
  logic [7:0]              sw_meta_q, sw_sync_q;
  logic [GPIO_NUM_BTN-1:0] btn_level, btn_rise;
  logic [GPIO_NUM_BTN-1:0] press_q, press_d;
  logic [g_WIDTH-1:0]      rdata_q, rdata_d, rd_mux;
  logic                    sel_q, sel_d;

  // Bit 8 of the write data has no register behind it.
  logic unused_data;
  assign unused_data = ^i_data[g_WIDTH-1:8];

  assign hit = i_en && (i_addr[g_ADDR-1:GPIO_WINDOW_BITS] == g_BASE[g_ADDR-1:GPIO_WINDOW_BITS]);
  assign off = i_addr[GPIO_WINDOW_BITS-1:0];
  assign wr  = hit & i_we;
  assign rd  = hit & i_re;

  for (genvar b = 0; b < GPIO_NUM_BTN; b++) begin : g_btn
    gpio_debounce #(
      .g_DB_BITS(g_DB_BITS)
    ) u_db (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_async(i_btn[b]),
      .o_level(btn_level[b]),
      .o_rise (btn_rise[b])
    );
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      GPIO_OFF_LED:   rd_mux[7:0]              = led_q;
      GPIO_OFF_SW:    rd_mux[7:0]              = sw_sync_q;
      GPIO_OFF_BTN:   rd_mux[GPIO_NUM_BTN-1:0] = btn_level;
      GPIO_OFF_PRESS: rd_mux[GPIO_NUM_BTN-1:0] = press_q;
      default:        rd_mux                   = '0;
    endcase
  end

  always_comb begin
    led_d   = led_q;
    press_d = press_q;
    if (wr && off == GPIO_OFF_LED) begin
      led_d = i_data[7:0];
    end
    if (wr && off == GPIO_OFF_PRESS) begin
      press_d = press_q & ~i_data[GPIO_NUM_BTN-1:0];
    end
    // A rise landing in the same cycle as a clear must not be lost.
    press_d = press_d | btn_rise;
    sel_d   = rd;
    rdata_d = rd ? rd_mux : rdata_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led_q     <= g_LED_RESET;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      press_q   <= '0;
      rdata_q   <= '0;
      sel_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= i_sw;
      sw_sync_q <= sw_meta_q;
      press_q   <= press_d;
      rdata_q   <= rdata_d;
      sel_q     <= sel_d;
    end
  end

  assign o_led  = led_q;
  assign o_data = rdata_q;
  assign o_sel  = sel_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// Randomized scoreboard bench for mmio_gpio with a short debounce counter.
module tb_mmio_gpio;

  localparam int          DB_BITS = 4;
  // Pin must hold a new value for 2 synchronizer samples plus 2^N-1 counts.
  localparam int          DB_CYC  = 2 + (2 ** DB_BITS - 1);
  localparam logic [10:0] BASE    = 11'h7F8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, we = 1'b0, re = 1'b0;
  logic [10:0] addr = '0;
  logic [8:0] wdata = '0;
  logic [8:0] o_data;
  logic       o_sel;
  logic [7:0] o_led;
  logic [7:0] sw = '0;
  logic [4:0] btn = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_gpio #(
    .g_ADDR(11), .g_WIDTH(9), .g_BASE(BASE), .g_LED_RESET(8'h99), .g_DB_BITS(DB_BITS)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .i_we  (we),
    .i_re  (re),
    .i_addr(addr),
    .i_data(wdata),
    .o_data(o_data),
    .o_sel (o_sel),
    .o_led (o_led),
    .i_sw  (sw),
    .i_btn (btn)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [8:0] sb[$];
  logic [7:0] m_led;
  logic [4:0] m_press, m_level, m_raw, m_rise;
  logic [7:0] sw_prev1, sw_prev2;
  int         m_first[5];
  int         edge_cnt = 0;
  logic       m_hit;
  logic [8:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_led    = 8'h99;
    m_press  = '0;
    m_level  = '0;
    m_raw    = '0;
    sw_prev1 = '0;
    sw_prev2 = '0;
    for (int b = 0; b < 5; b++) m_first[b] = 0;
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst) begin
      m_hit = en && (addr[10:3] == BASE[10:3]);
      if (m_hit && re) begin
        case (addr[2:0])
          3'd0:    m_rd = {1'b0, m_led};
          3'd1:    m_rd = {1'b0, sw_prev2};
          3'd2:    m_rd = {4'b0, m_level};
          3'd3:    m_rd = {4'b0, m_press};
          default: m_rd = '0;
        endcase
        sb.push_back(m_rd);
      end
      m_rise = '0;
      for (int b = 0; b < 5; b++) begin
        if (btn[b] != m_raw[b]) begin
          m_raw[b]   = btn[b];
          m_first[b] = edge_cnt;
        end
        if (m_raw[b] != m_level[b] && (edge_cnt - m_first[b] + 1) >= DB_CYC) begin
          m_level[b] = m_raw[b];
          m_rise[b]  = m_raw[b];
        end
      end
      if (m_hit && we && addr[2:0] == 3'd0) m_led = wdata[7:0];
      if (m_hit && we && addr[2:0] == 3'd3) m_press = m_press & ~wdata[4:0];
      m_press  = m_press | m_rise;
      sw_prev2 = sw_prev1;
      sw_prev1 = sw;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("led", {24'b0, o_led}, {24'b0, m_led});
      if (o_sel) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sel_unexpected: got o_sel=1 o_data=%0h expected no read at %0t", o_data, $time);
        end else begin
          check("rdata", {23'b0, o_data}, {23'b0, sb.pop_front()});
        end
      end else if (sb.size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sel_missing: got o_sel=0 expected read data %0h at %0t", sb[0], $time);
        sb.delete();
      end
    end
  end

  task automatic op(input logic e, input logic w, input logic r, input logic [10:0] a,
                    input logic [8:0] d);
    en = e; we = w; re = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic wr_reg(input logic [10:0] a, input logic [8:0] d);
    op(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_reg(input logic [10:0] a);
    op(1'b1, 1'b0, 1'b1, a, 9'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_sel", {31'b0, o_sel}, 32'h0);
    check("rst_led", {24'b0, o_led}, 32'h99);
    check("rst_data", {23'b0, o_data}, 32'h0);
    idle(cycles);
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle(1);
    do_reset(3);

    // 1: reset value readback
    rd_reg(11'h7F8);
    idle(1);

    // 2: LED write ignores bit 8; miss leaves state untouched
    wr_reg(11'h7F8, 9'h1A5);
    rd_reg(11'h7F8);
    check("led_after_write", {24'b0, o_led}, 32'hA5);
    wr_reg(11'h7F0, 9'h0FF);
    rd_reg(11'h7F0);
    check("miss_sel", {31'b0, o_sel}, 32'h0);
    check("miss_led", {24'b0, o_led}, 32'hA5);

    // 3: switches, read-only SW, unused offsets
    sw = 8'h3C;
    idle(3);
    rd_reg(11'h7F9);
    wr_reg(11'h7F9, 9'h1FF);
    rd_reg(11'h7F9);
    for (int i = 4; i < 8; i++) begin
      wr_reg(BASE | 11'(i), 9'h1FF);
      op(1'b1, 1'b1, 1'b1, BASE | 11'(i), 9'h1FF);
    end

    // 4: bouncing button never settles, then a clean hold does
    for (int i = 0; i < 10; i++) begin
      btn[2] = (i % 2 == 0);
      repeat (3) rd_reg(11'h7FA);
    end
    btn[2] = 1'b1;
    idle(20);
    rd_reg(11'h7FA);
    rd_reg(11'h7FB);

    // 5: clear coinciding with a fresh rise, then a plain clear
    btn[2] = 1'b0;
    wr_reg(11'h7FB, 9'h004);
    rd_reg(11'h7FB);
    idle(23);
    rd_reg(11'h7FA);
    btn[2] = 1'b1;
    idle(DB_CYC - 1);
    wr_reg(11'h7FB, 9'h004);
    rd_reg(11'h7FB);
    rd_reg(11'h7FA);
    wr_reg(11'h7FB, 9'h004);
    rd_reg(11'h7FB);

    // 6: reset during a pending read and a partial debounce
    btn = 5'h01;
    idle(8);
    rd_reg(11'h7F8);
    do_reset(2);
    idle(10);
    rd_reg(11'h7FA);
    idle(20);
    rd_reg(11'h7FA);
    rd_reg(11'h7FB);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [10:0] a;
      if ($urandom_range(0, 19) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 39) == 0) btn = 5'($urandom);
      a = ($urandom_range(0, 1) == 0) ? (BASE | 11'($urandom_range(0, 7))) : 11'($urandom);
      op($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), a, 9'($urandom));
    end
    idle(2);

    check("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
